tsc_sequencer: RTL and testbench
================================

# tsc_sequencer

Multi-cycle control sequencer for the TSC register/ALU datapath. Owns the PC and instruction register, fetches each 16-bit instruction from memory over a request/ready handshake, decodes it, and drives the datapath control strobes for exactly one execute cycle per instruction. Sits between the instruction memory port and the datapath, replacing the hard-wired control of the single-cycle build.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000, PC value loaded at reset.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  synchronous active-low reset
- `readM`  out  1  fetch request, held high until `inputReady`
- `address`  out  16  fetch address (= PC)
- `data`  in  16  instruction word, valid when `inputReady`=1
- `inputReady`  in  1  memory has `data` this cycle
- `opinstruction`  out  16  instruction register, feeds datapath field extraction
- `Jump`  out  1  JMP executing
- `ALU_OP`  out  4  ALU operation select
- `ALUSrc`  out  1  1 = sign-extended immediate as ALU operand 2
- `RegDst`  out  1  1 = write rd, 0 = write rt
- `RegWrite`  out  1  register file write enable
- `wwd_valid`  out  1  WWD executing; `output_data` is valid
- `num_inst`  out  16  retired-instruction count
- `halted`  out  1  sequencer stopped by HLT

## Operation
- States: RST, FETCH, EXEC, HALT (HALT only with macro).
- RST: entered on any edge with `reset_n`=0; next edge with `reset_n`=1 -> FETCH.
- FETCH: `readM`=1, `address`=PC. On edge with `inputReady`=1: IR <= `data`, -> EXEC. Otherwise stay; `address` stable.
- EXEC (exactly one cycle): decode IR[15:12] opcode, IR[5:0] func; assert controls; at the edge: PC update, `num_inst` += 1, -> FETCH.
- Decode:
  - Opcode 15, func 0..7: `RegDst`=1, `RegWrite`=1, `ALUSrc`=0, `ALU_OP`=func[3:0].
  - ADI (4): `RegWrite`=1, `ALUSrc`=1, `ALU_OP`=ALU_ADD.
  - ORI (5): same, `ALU_OP`=ALU_OR.
  - LHI (6): same, `ALU_OP`=ALU_LHI.
  - JMP (9): `Jump`=1; PC <= {PC[15:12], IR[11:0]}.
  - WWD (15/28): `wwd_valid`=1.
  - HLT (15/29): see Configuration.
  - Anything else: NOP.
- Non-jump PC update: PC <= PC+1, mod 2^16 (16'hFFFF -> 16'h0000). JMP keeps the upper nibble of the *current* PC.
- `num_inst` wraps 16'hFFFF -> 0. Every executed instruction counts, including NOP, WWD and HLT.
- All control outputs (`Jump`, `ALU_OP`=0, `ALUSrc`, `RegDst`, `RegWrite`, `wwd_valid`) are 0 outside EXEC.

## Timing
- Reset values: PC=`RESET_PC`, IR=0, `num_inst`=0, `halted`=0, all strobes 0, `readM`=0.
- `readM` rises in the first cycle after reset release.
- Latency: minimum 2 cycles per instruction (1 FETCH with `inputReady` + 1 EXEC). Each wait cycle adds 1.
- `inputReady` outside FETCH is ignored.
- `address`/`readM` are registered-state decodes: no combinational path from `inputReady`.
- Reset mid-fetch or mid-EXEC: the edge with `reset_n`=0 aborts. No register write is suppressed retroactively, but PC/count updates from that edge do not occur; `readM` is 0 the cycle after.

## Configuration
- `TSC_HALT_EN` defined:
  - HLT in EXEC -> HALT; `halted`=1, `readM`=0; stays until reset.
  - `num_inst` counts HLT; PC is not advanced.
- Undefined: HLT decodes as NOP, PC+1; `halted` tied 0; HALT state absent.

## Structure
- Shared package/header: opcode and func constants (ADI, ORI, LHI, JMP, WWD, HLT, R-type func), ALU_OP codes (ALU_ADD, ALU_OR, ALU_LHI), state encoding, field bit positions (opcode, rs, rt, rd, imm, target), WORD_SIZE.
- One sub-module: `tsc_decoder`, purely combinational, IR -> control bundle. The sequencer gates its output with EXEC.

## Test plan
- Reset release, memory `inputReady` same cycle as `readM` -> `address`=0, then 1, 2 on successive FETCHes; 2 cycles per instruction; `num_inst`=3 after three NOPs.
- `inputReady` delayed 3 cycles -> `readM` held high 4 cycles, `address` stable, controls 0 throughout.
- IR=16'hF1C0 (ADD, rd=3) -> one EXEC cycle with `RegDst`=1, `RegWrite`=1, `ALUSrc`=0, `ALU_OP`=0. IR=16'h4105 (ADI) -> `ALUSrc`=1, `RegDst`=0, `ALU_OP`=ALU_ADD.
- PC=16'h5FF0, IR=16'h9123 (JMP) -> `Jump`=1 for one cycle, next `address`=16'h5123. PC=16'hFFFF NOP -> next `address`=16'h0000.
- IR=16'hF01D (HLT) with `TSC_HALT_EN` -> `halted`=1, `readM` stays 0, count incremented once. Without macro -> fetch continues at PC+1.
- `reset_n` low during FETCH wait -> next cycle `readM`=0, `num_inst`=0, then `address` restarts at `RESET_PC`.

Source files
------------

// File: rtl/tsc_sequencer_pkg.sv
// Shared constants for the TSC sequencer: opcodes, func codes, ALU selects,
// instruction field positions, state encoding and the decoded control bundle.
package tsc_sequencer_pkg;

  localparam int WORD_SIZE = 16;

  // Instruction field bit positions
  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 12;
  localparam int RS_MSB     = 11;
  localparam int RS_LSB     = 10;
  localparam int RT_MSB     = 9;
  localparam int RT_LSB     = 8;
  localparam int RD_MSB     = 7;
  localparam int RD_LSB     = 6;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 11;
  localparam int TARGET_LSB = 0;

  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type arithmetic funcs occupy 0..FUNC_RMAX and map straight onto ALU_OP
  localparam logic [5:0] FUNC_RMAX = 6'd7;
  localparam logic [5:0] FUNC_WWD  = 6'd28;
  localparam logic [5:0] FUNC_HLT  = 6'd29;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_LHI = 4'd8;

  typedef enum logic [1:0] {
    ST_RST,
    ST_FETCH,
    ST_EXEC
`ifdef TSC_HALT_EN
    , ST_HALT
`endif
  } state_t;

  typedef struct packed {
    logic       jump;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       wwd;
`ifdef TSC_HALT_EN
    logic       hlt;
`endif
  } ctrl_t;

endpackage

// File: rtl/tsc_sequencer_if.sv
// Instruction-memory fetch port: request/address out, data/ready back.
interface tsc_sequencer_if;
  import tsc_sequencer_pkg::*;

  logic                 readM;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] data;
  logic                 inputReady;

  modport master (output readM, output address, input data, input inputReady);
  modport slave  (input readM, input address, output data, output inputReady);
endinterface

// File: rtl/tsc_decoder.sv
// Combinational instruction decode: opcode/func -> control bundle.
// The HLT flag exists only when TSC_HALT_EN is defined; otherwise HLT is a NOP.
module tsc_decoder
  import tsc_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        if (func <= FUNC_RMAX) begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = func[3:0];
        end else if (func == FUNC_WWD) begin
          ctrl.wwd = 1'b1;
        end
`ifdef TSC_HALT_EN
        else if (func == FUNC_HLT) begin
          ctrl.hlt = 1'b1;
        end
`endif
      end
      OP_ADI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_LHI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LHI;
      end
      OP_JMP:  ctrl.jump = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/tsc_sequencer.sv
// Multi-cycle fetch/execute sequencer for the TSC datapath.
// Optional HLT support is built when TSC_HALT_EN is defined.
module tsc_sequencer
  import tsc_sequencer_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = 16'h0000
)(
  input  logic                 clk,
  input  logic                 reset_n,
  tsc_sequencer_if.master      mem,
  output logic [WORD_SIZE-1:0] opinstruction,
  output logic                 Jump,
  output logic [3:0]           ALU_OP,
  output logic                 ALUSrc,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 wwd_valid,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 halted
);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;
  ctrl_t                ctrl;
  logic                 in_exec;

  tsc_decoder u_decoder (
    .opcode (ir_q[OP_MSB:OP_LSB]),
    .func   (ir_q[FUNC_MSB:FUNC_LSB]),
    .ctrl   (ctrl)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    num_inst_d = num_inst_q;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem.inputReady) begin
          ir_d    = mem.data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        num_inst_d = num_inst_q + 16'd1;
        state_d    = ST_FETCH;
        if (ctrl.jump) begin
          // JMP stays within the current 4K page
          pc_d = {pc_q[OP_MSB:OP_LSB], ir_q[TARGET_MSB:TARGET_LSB]};
        end
`ifdef TSC_HALT_EN
        else if (ctrl.hlt) begin
          state_d = ST_HALT;
        end
`endif
        else begin
          pc_d = pc_q + 16'd1;
        end
      end
`ifdef TSC_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      num_inst_q <= num_inst_d;
    end
  end

  // Fetch outputs decode registered state only, so no path from inputReady
  assign mem.readM   = (state_q == ST_FETCH);
  assign mem.address = pc_q;

  assign in_exec       = (state_q == ST_EXEC);
  assign opinstruction = ir_q;
  assign num_inst      = num_inst_q;
  assign Jump          = in_exec & ctrl.jump;
  assign ALU_OP        = in_exec ? ctrl.alu_op : 4'd0;
  assign ALUSrc        = in_exec & ctrl.alu_src;
  assign RegDst        = in_exec & ctrl.reg_dst;
  assign RegWrite      = in_exec & ctrl.reg_write;
  assign wwd_valid     = in_exec & ctrl.wwd;

`ifdef TSC_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_tsc_sequencer.sv
// Scoreboard bench for tsc_sequencer: a driver plays memory and queues the
// expected fetch/exec behaviour; a monitor checks it on the falling edge.
module tb_tsc_sequencer;
  import tsc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] opinstruction;
  logic        Jump;
  logic [3:0]  ALU_OP;
  logic        ALUSrc;
  logic        RegDst;
  logic        RegWrite;
  logic        wwd_valid;
  logic [15:0] num_inst;
  logic        halted;

  always #5 clk = ~clk;

  tsc_sequencer_if mem ();

  tsc_sequencer #(.RESET_PC(16'hFFFE)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem           (mem),
    .opinstruction (opinstruction),
    .Jump          (Jump),
    .ALU_OP        (ALU_OP),
    .ALUSrc        (ALUSrc),
    .RegDst        (RegDst),
    .RegWrite      (RegWrite),
    .wwd_valid     (wwd_valid),
    .num_inst      (num_inst),
    .halted        (halted)
  );

  // flags = {Jump, ALUSrc, RegDst, RegWrite, wwd_valid}
  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    int          waits;
    logic [3:0]  op;
    logic [4:0]  flags;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   pending = 1'b0;
  int   fetch_cycles = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] a, input logic [15:0] i, input int w,
                              input logic [3:0] op, input logic [4:0] f, input logic [15:0] c);
    exp_t e;
    e.addr = a; e.instr = i; e.waits = w; e.op = op; e.flags = f; e.count = c;
    return e;
  endfunction

  task automatic issue(input exp_t e);
    int n = 0;
    exp_q.push_back(e);
    while (!mem.readM && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!mem.readM) begin
      chk("readM_timeout", 32'(mem.readM), 32'd1);
      return;
    end
    repeat (e.waits) begin
      @(posedge clk); #1;
    end
    mem.data       = e.instr;
    mem.inputReady = 1'b1;
    @(posedge clk); #1;
    mem.inputReady = 1'b0;
    mem.data       = 16'hDEAD;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_readM"}, 32'(mem.readM), 32'd0);
    chk({tag, "_address"}, 32'(mem.address), 32'hFFFE);
    chk({tag, "_num_inst"}, 32'(num_inst), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_ir"}, 32'(opinstruction), 32'd0);
    chk({tag, "_ctrl"}, 32'({Jump, ALU_OP, ALUSrc, RegDst, RegWrite, wwd_valid}), 32'd0);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (pending) begin
        chk("exec_ir", 32'(opinstruction), 32'(cur.instr));
        chk("exec_flags", 32'({Jump, ALUSrc, RegDst, RegWrite, wwd_valid}), 32'(cur.flags));
        chk("exec_alu_op", 32'(ALU_OP), 32'(cur.op));
        chk("exec_count", 32'(num_inst), 32'(cur.count));
        chk("exec_readM", 32'(mem.readM), 32'd0);
        $display("exec  addr=%h ir=%h flags=%b alu_op=%0d count=%0d",
                 cur.addr, opinstruction, {Jump, ALUSrc, RegDst, RegWrite, wwd_valid}, ALU_OP, num_inst);
        pending = 1'b0;
      end else if (reset_n && mem.readM && exp_q.size() > 0) begin
        fetch_cycles++;
        chk("fetch_addr", 32'(mem.address), 32'(exp_q[0].addr));
        chk("fetch_ctrl", 32'({Jump, ALU_OP, ALUSrc, RegDst, RegWrite, wwd_valid}), 32'd0);
        if (mem.inputReady) begin
          cur = exp_q.pop_front();
          chk("fetch_cycles", 32'(fetch_cycles), 32'(cur.waits + 1));
          fetch_cycles = 0;
          pending      = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin : stimulus
    reset_n        = 1'b0;
    mem.inputReady = 1'b0;
    mem.data       = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("readM_rise", 32'(mem.readM), 32'd1);

    issue(mk(16'hFFFE, 16'h0000, 0, 4'd0, 5'b00000, 16'd0));
    issue(mk(16'hFFFF, 16'h0000, 0, 4'd0, 5'b00000, 16'd1));   // PC wraps to 0
    issue(mk(16'h0000, 16'hF1C0, 0, 4'd0, 5'b00110, 16'd2));   // ADD
    issue(mk(16'h0001, 16'h4105, 3, 4'd0, 5'b01010, 16'd3));   // ADI, 3 wait cycles
    issue(mk(16'h0002, 16'h5207, 1, 4'd3, 5'b01010, 16'd4));   // ORI
    issue(mk(16'h0003, 16'h6301, 0, 4'd8, 5'b01010, 16'd5));   // LHI
    issue(mk(16'h0004, 16'hF1C7, 0, 4'd7, 5'b00110, 16'd6));   // R-type func 7
    issue(mk(16'h0005, 16'hF01C, 0, 4'd0, 5'b00001, 16'd7));   // WWD
    issue(mk(16'h0006, 16'hF008, 0, 4'd0, 5'b00000, 16'd8));   // func 8 -> NOP
    issue(mk(16'h0007, 16'h9FFE, 0, 4'd0, 5'b10000, 16'd9));   // JMP -> 0FFE
    issue(mk(16'h0FFE, 16'h2000, 0, 4'd0, 5'b00000, 16'd10));
    issue(mk(16'h0FFF, 16'h0000, 0, 4'd0, 5'b00000, 16'd11));
    issue(mk(16'h1000, 16'h9123, 0, 4'd0, 5'b10000, 16'd12));  // JMP keeps page 1
    issue(mk(16'h1123, 16'h0000, 2, 4'd0, 5'b00000, 16'd13));
    issue(mk(16'h1124, 16'hF01D, 0, 4'd0, 5'b00000, 16'd14));  // HLT

`ifdef TSC_HALT_EN
    @(posedge clk); #1;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_readM", 32'(mem.readM), 32'd0);
    chk("halt_count", 32'(num_inst), 32'd15);
    chk("halt_pc", 32'(mem.address), 32'h1124);
    mem.inputReady = 1'b1;
    mem.data       = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    mem.inputReady = 1'b0;
    chk("halt_stay", 32'(halted), 32'd1);
    chk("halt_stay_readM", 32'(mem.readM), 32'd0);
    chk("halt_stay_count", 32'(num_inst), 32'd15);
`else
    chk("halted_tied", 32'(halted), 32'd0);
    issue(mk(16'h1125, 16'h0000, 0, 4'd0, 5'b00000, 16'd15));
    @(posedge clk); #1;
    chk("post_hlt_readM", 32'(mem.readM), 32'd1);
    chk("post_hlt_addr", 32'(mem.address), 32'h1126);
    chk("post_hlt_count", 32'(num_inst), 32'd16);
`endif

    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset("rst1");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_readM", 32'(mem.readM), 32'd1);
    chk("restart_addr", 32'(mem.address), 32'hFFFE);

    // Abort a fetch that is still waiting on memory
    issue(mk(16'hFFFE, 16'h0000, 0, 4'd0, 5'b00000, 16'd0));
    @(posedge clk); #1;
    chk("abort_pre_count", 32'(num_inst), 32'd1);
    chk("abort_pre_addr", 32'(mem.address), 32'hFFFF);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset("rst2");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_readM", 32'(mem.readM), 32'd1);
    chk("abort_addr", 32'(mem.address), 32'hFFFE);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
